// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM states, exception
// and result-source codes, and the load-use detection helper.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_MEM_WAIT  = 2'd1,
    ST_EXC_FLUSH = 2'd2
  } ctrl_state_e;

  localparam logic [3:0] EXC_NONE              = 4'hF;
  localparam logic [1:0] RES_SRC_LOAD          = 2'b01;
  localparam logic [3:0] EXC_MEM_FAULT_DEFAULT = 4'h5;

  // A load in EX whose non-zero destination feeds either ID source operand.
  function automatic logic load_use_hazard(
    input logic [4:0] rs1_d,
    input logic [4:0] rs2_d,
    input logic [4:0] rd_e,
    input logic [1:0] result_src_e
  );
    return (result_src_e == RES_SRC_LOAD) && (rd_e != 5'd0) &&
           ((rd_e == rs1_d) || (rd_e == rs2_d));
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts data-memory wait cycles; flags expiry once LIMIT cycles have elapsed.
module mem_wait_timer #(
  parameter int LIMIT = 15,
  parameter int W     = $clog2(LIMIT + 2)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         enable,
  output logic [W-1:0] count,
  output logic         expired
);

  logic [W-1:0] count_reg;
  logic [W-1:0] count_next;

  assign expired = (count_reg == W'(LIMIT));
  assign count   = count_reg;

  always_comb begin
    count_next = count_reg;
    if (clear) begin
      count_next = '0;
    end else if (enable && !expired) begin
      count_next = count_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline hazard controller: load-use stalls, branch flushes,
// data-memory wait stalls with timeout fault, and exception trap sequencing.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int         MEM_TIMEOUT   = 15,
  parameter logic [3:0] EXC_MEM_FAULT = EXC_MEM_FAULT_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [4:0]  i_rs1_d,
  input  logic [4:0]  i_rs2_d,
  input  logic [4:0]  i_rd_e,
  input  logic [1:0]  i_result_src_e,
  input  logic        i_pc_src_e,
  input  logic [3:0]  i_exception_code_e,
  input  logic        i_mem_req_m,
  input  logic        i_mem_ready,
  output logic        o_stall_f,
  output logic        o_en_if_id,
  output logic        o_en_id_ex,
  output logic        o_en_ex_mem,
  output logic        o_en_mem_wb,
  output logic        o_flush_if_id,
  output logic        o_flush_id_ex,
  output logic        o_flush_ex_mem,
  output logic        o_trap_redirect,
  output logic        o_exc_valid,
  output logic [3:0]  o_exc_code,
  output logic [31:0] o_stall_cycles
);

  localparam int TW = $clog2(MEM_TIMEOUT + 2);

  ctrl_state_e state_reg;
  ctrl_state_e state_next;
  logic [3:0]  exc_code_reg;
  logic [3:0]  exc_code_next;
  logic [31:0] stall_cycles_reg;
  logic        timer_clear;
  logic        timer_enable;
  logic        timer_expired;
  logic [TW-1:0] timer_count;
  logic        load_use;
  logic        exc_pending;
  logic        mem_stall_req;
  logic        trap_active;

  mem_wait_timer #(
    .LIMIT (MEM_TIMEOUT),
    .W     (TW)
  ) u_mem_wait_timer (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .clear   (timer_clear),
    .enable  (timer_enable),
    .count   (timer_count),
    .expired (timer_expired)
  );

  assign load_use      = load_use_hazard(i_rs1_d, i_rs2_d, i_rd_e, i_result_src_e);
  assign exc_pending   = (i_exception_code_e != EXC_NONE);
  assign mem_stall_req = i_mem_req_m && !i_mem_ready;

  always_comb begin
    state_next      = state_reg;
    exc_code_next   = exc_code_reg;
    timer_clear     = 1'b0;
    timer_enable    = 1'b0;
    trap_active     = 1'b0;
    o_stall_f       = 1'b0;
    o_en_if_id      = 1'b1;
    o_en_id_ex      = 1'b1;
    o_en_ex_mem     = 1'b1;
    o_en_mem_wb     = 1'b1;
    o_flush_if_id   = 1'b0;
    o_flush_id_ex   = 1'b0;
    o_flush_ex_mem  = 1'b0;

    case (state_reg)
      ST_RUN: begin
        if (exc_pending) begin
          exc_code_next  = i_exception_code_e;
          o_flush_if_id  = 1'b1;
          o_flush_id_ex  = 1'b1;
          o_flush_ex_mem = 1'b1;
          state_next     = ST_EXC_FLUSH;
        end else if (mem_stall_req) begin
          o_stall_f   = 1'b1;
          o_en_if_id  = 1'b0;
          o_en_id_ex  = 1'b0;
          o_en_ex_mem = 1'b0;
          o_en_mem_wb = 1'b0;
          timer_clear = 1'b1;
          state_next  = ST_MEM_WAIT;
        end else if (i_pc_src_e) begin
          o_flush_if_id = 1'b1;
          o_flush_id_ex = 1'b1;
        end else if (load_use) begin
          // The bubble moves the load into MEM next cycle, so the stall self-terminates.
          o_stall_f     = 1'b1;
          o_en_if_id    = 1'b0;
          o_flush_id_ex = 1'b1;
        end
      end

      ST_MEM_WAIT: begin
        if (i_mem_ready) begin
          state_next = ST_RUN;
        end else begin
          o_stall_f   = 1'b1;
          o_en_if_id  = 1'b0;
          o_en_id_ex  = 1'b0;
          o_en_ex_mem = 1'b0;
          o_en_mem_wb = 1'b0;
          if (timer_expired) begin
            exc_code_next  = EXC_MEM_FAULT;
            o_flush_if_id  = 1'b1;
            o_flush_id_ex  = 1'b1;
            o_flush_ex_mem = 1'b1;
            state_next     = ST_EXC_FLUSH;
          end else begin
            timer_enable = 1'b1;
          end
        end
      end

      ST_EXC_FLUSH: begin
        trap_active   = 1'b1;
        o_flush_if_id = 1'b1;
        o_flush_id_ex = 1'b1;
        state_next    = ST_RUN;
      end

      default: begin
        state_next = ST_RUN;
      end
    endcase
  end

  // Gated by reset so a trap being discarded by reset never reaches the PC mux.
  assign o_exc_valid     = trap_active && i_rst_n;
  assign o_trap_redirect = trap_active && i_rst_n;
  assign o_exc_code      = exc_code_reg;
  assign o_stall_cycles  = stall_cycles_reg;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_reg        <= ST_RUN;
      exc_code_reg     <= EXC_NONE;
      stall_cycles_reg <= '0;
    end else begin
      state_reg    <= state_next;
      exc_code_reg <= exc_code_next;
      if (!o_en_if_id && (stall_cycles_reg != 32'hFFFF_FFFF)) begin
        stall_cycles_reg <= stall_cycles_reg + 32'd1;
      end
    end
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15, the maximum number of wait cycles allowed for a data-memory access before a fault is raised.
REQ-002 SHALL have parameter EXC_MEM_FAULT, default 4'h5, the exception code raised on a memory timeout.
REQ-003 SHALL have port i_clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_rst_n, input, 1, reset, synchronous and active-low.
REQ-005 SHALL have port i_rs1_d, input, 5, the ID-stage source register 1.
REQ-006 SHALL have port i_rs2_d, input, 5, the ID-stage source register 2.
REQ-007 SHALL have port i_rd_e, input, 5, the EX-stage destination register.
REQ-008 SHALL have port i_result_src_e, input, 2, the EX-stage result source; 2'b01 means load.
REQ-009 SHALL have port i_pc_src_e, input, 1, branch/jump taken in EX.
REQ-010 SHALL have port i_exception_code_e, input, 4, the EX exception code; 4'hF means none.
REQ-011 SHALL have port i_mem_req_m, input, 1, a load or store is present in MEM.
REQ-012 SHALL have port i_mem_ready, input, 1, the data memory has completed the access.
REQ-013 SHALL have outputs o_stall_f, o_en_if_id, o_en_id_ex, o_en_ex_mem and o_en_mem_wb, each 1 bit: PC hold plus per-register clock enables.
REQ-014 SHALL have outputs o_flush_if_id, o_flush_id_ex and o_flush_ex_mem, each 1 bit, synchronous clears.
REQ-015 SHALL have output o_trap_redirect, 1, select trap vector for the next PC.
REQ-016 SHALL have outputs o_exc_valid, 1, and o_exc_code, 4, the taken exception pulse and its code.
REQ-017 SHALL have output o_stall_cycles, 32, a saturating count of stalled cycles.

Function
REQ-018 SHALL implement FSM states RUN, MEM_WAIT and EXC_FLUSH; stage enables and flushes are combinational from state and inputs.
REQ-019 In RUN with no event, SHALL drive all enables=1, all flushes=0, o_stall_f=0.
REQ-020 Priority in RUN SHALL be exception > memory wait > branch > load-use; only the highest-priority action applies.
REQ-021 If i_exception_code_e!=4'hF in RUN: latch the code, assert all three flushes this cycle, next state EXC_FLUSH.
REQ-022 If i_mem_req_m=1 and i_mem_ready=0 in RUN: all enables=0, o_stall_f=1, timer cleared, next state MEM_WAIT.
REQ-023 If i_pc_src_e=1: assert o_flush_if_id and o_flush_id_ex with enables=1.
REQ-024 Load-use is i_result_src_e==2'b01, i_rd_e!=0, and i_rd_e equals i_rs1_d or i_rs2_d; on load-use: o_stall_f=1, o_en_if_id=0, o_flush_id_ex=1, remaining enables=1, for exactly one cycle.
REQ-025 In MEM_WAIT: all enables=0 and o_stall_f=1; the timer increments each cycle.
REQ-026 In MEM_WAIT with i_mem_ready=1: enables=1 that same cycle, next state RUN.
REQ-027 When the timer reaches MEM_TIMEOUT with no ready: latch EXC_MEM_FAULT, all flushes=1, next state EXC_FLUSH.
REQ-028 If i_mem_ready and timeout coincide, ready SHALL win.
REQ-029 EXC_FLUSH SHALL last exactly one cycle: o_exc_valid=1, o_trap_redirect=1, o_exc_code=latched code, o_flush_if_id=o_flush_id_ex=1, enables=1; next state RUN.
REQ-030 o_stall_cycles SHALL increment on each cycle where o_en_if_id=0 and saturate at 32'hFFFFFFFF.
REQ-031 o_exc_code SHALL hold its last latched value outside EXC_FLUSH.

Reset
REQ-032 While i_rst_n=0 at a clock edge: state=RUN, timer=0, o_exc_code=4'hF, o_stall_cycles=0.
REQ-033 Mid-operation reset, including in MEM_WAIT or EXC_FLUSH, SHALL discard the pending wait or exception, with no o_exc_valid pulse.

Structure
REQ-034 Package pipe_ctrl_pkg SHALL hold the FSM state encoding, EXC_NONE=4'hF, RES_SRC_LOAD=2'b01 and the default fault code.
REQ-035 The timeout counter SHALL be a sub-module mem_wait_timer (clear, enable, count, expired).

Verification
REQ-036 Load-use: x5 loaded in EX, i_rs1_d=5 -> one cycle with o_en_if_id=0, o_stall_f=1, o_flush_id_ex=1; o_stall_cycles=1.
REQ-037 Load with rd=0 and i_rs1_d=0 -> no stall.
REQ-038 Memory wait: i_mem_ready low for 3 cycles, then high -> enables=0 for 3 cycles, returns to RUN, o_stall_cycles=3.
REQ-039 Timeout: i_mem_ready never high -> o_exc_valid pulse with o_exc_code=4'h5 and o_trap_redirect=1 after MEM_TIMEOUT wait cycles.
REQ-040 Simultaneous exception code 4'h2, branch taken and load-use -> three flushes, then EXC_FLUSH with o_exc_code=4'h2; no load-use stall.
REQ-041 i_rst_n=0 during MEM_WAIT -> next cycle RUN, o_stall_cycles=0, o_exc_code=4'hF, no o_exc_valid pulse.
